// File: rtl/multiport_register_file.sv
// Multi-port register file: one byte-enabled write port, READ_PORTS registered read ports
// with write-first bypass, and a sweep sequencer that zeroes every entry after reset or on request.
module multiport_register_file #(
  parameter  int DATA_WIDTH = 32,
  parameter  int DEPTH      = 64,
  parameter  int READ_PORTS = 2,
  localparam int ADDR_WIDTH = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int BE_WIDTH   = DATA_WIDTH / 8
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             clear_in,
  output logic                             busy_out,
  input  logic                             w_en_in,
  input  logic [ADDR_WIDTH-1:0]            w_addr_in,
  input  logic [BE_WIDTH-1:0]              w_be_in,
  input  logic [DATA_WIDTH-1:0]            w_data_in,
  input  logic [READ_PORTS-1:0]            r_en_in,
  input  logic [READ_PORTS*ADDR_WIDTH-1:0] r_addr_in,
  output logic [READ_PORTS*DATA_WIDTH-1:0] r_data_out,
  output logic [READ_PORTS-1:0]            r_valid_out
);

  typedef enum logic {
    ST_CLEAR,
    ST_READY
  } state_t;

  localparam logic [ADDR_WIDTH-1:0] LAST_PTR  = ADDR_WIDTH'(DEPTH - 1);
  localparam logic [ADDR_WIDTH:0]   DEPTH_EXT = (ADDR_WIDTH + 1)'(DEPTH);

  function automatic logic in_range(input logic [ADDR_WIDTH-1:0] addr);
    return {1'b0, addr} < DEPTH_EXT;
  endfunction

  state_t                          state_q, state_d;
  logic [ADDR_WIDTH-1:0]           ptr_q, ptr_d;
  logic [DATA_WIDTH-1:0]           mem [DEPTH];
  logic                            ready;
  logic                            w_fire;
  logic [READ_PORTS-1:0]           rd_fire;
  logic [ADDR_WIDTH-1:0]           rd_addr [READ_PORTS];
  logic [DATA_WIDTH-1:0]           rd_word [READ_PORTS];
  logic [READ_PORTS*DATA_WIDTH-1:0] r_data_q;
  logic [READ_PORTS-1:0]           r_valid_q;

  assign ready       = (state_q == ST_READY);
  assign busy_out    = (state_q == ST_CLEAR);
  assign w_fire      = ready && w_en_in && in_range(w_addr_in);
  assign r_data_out  = r_data_q;
  assign r_valid_out = r_valid_q;

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_CLEAR;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
    end
  end

  // NOTE: every output of a combinational block gets a default first so no latch is inferred.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    unique case (state_q)
      ST_CLEAR: begin
        if (ptr_q == LAST_PTR) begin
          state_d = ST_READY;
          ptr_d   = '0;
        end else begin
          ptr_d = ptr_q + ADDR_WIDTH'(1);
        end
      end
      ST_READY: begin
        if (clear_in) begin
          state_d = ST_CLEAR;
          ptr_d   = '0;
        end
      end
      default: begin
        state_d = ST_CLEAR;
        ptr_d   = '0;
      end
    endcase
  end

  // NOTE: the array has no reset; the sweep sequencer zeroes it one entry per cycle instead.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state_q == ST_CLEAR) begin
        mem[ptr_q] <= '0;
      end else if (w_fire) begin
        for (int k = 0; k < BE_WIDTH; k++) begin
          if (w_be_in[k]) mem[w_addr_in][8*k +: 8] <= w_data_in[8*k +: 8];
        end
      end
    end
  end

  // Read word per port, with same-cycle write bytes merged over the stored word.
  always_comb begin
    rd_fire = r_en_in & {READ_PORTS{ready}};
    for (int p = 0; p < READ_PORTS; p++) begin
      rd_addr[p] = r_addr_in[p*ADDR_WIDTH +: ADDR_WIDTH];
      rd_word[p] = '0;
      if (in_range(rd_addr[p])) begin
        rd_word[p] = mem[rd_addr[p]];
        if (w_en_in && (rd_addr[p] == w_addr_in)) begin
          for (int k = 0; k < BE_WIDTH; k++) begin
            if (w_be_in[k]) rd_word[p][8*k +: 8] = w_data_in[8*k +: 8];
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_data_q  <= '0;
      r_valid_q <= '0;
    end else begin
      r_valid_q <= rd_fire;
      for (int p = 0; p < READ_PORTS; p++) begin
        if (rd_fire[p]) r_data_q[p*DATA_WIDTH +: DATA_WIDTH] <= rd_word[p];
      end
    end
  end

endmodule

// File: tb/tb_multiport_register_file.sv
// Bench for multiport_register_file: two instances (DEPTH 64 and 48) share stimulus and are
// checked by a queue scoreboard fed from an array-based reference model.
module tb_multiport_register_file;

  localparam int DW = 32;
  localparam int AW = 6;
  localparam int RP = 2;
  localparam int DEP [2] = '{64, 48};

  logic             clk = 1'b0;
  logic             rst;
  logic             clear_in;
  logic             w_en;
  logic [AW-1:0]    w_addr;
  logic [3:0]       w_be;
  logic [DW-1:0]    w_data;
  logic [RP-1:0]    r_en;
  logic [RP*AW-1:0] r_addr;

  logic             busy_w   [2];
  logic [RP*DW-1:0] rdata_w  [2];
  logic [RP-1:0]    rvalid_w [2];

  int n_checks = 0;
  int n_err    = 0;
  bit mon_en   = 1'b0;

  logic [DW-1:0] m_mem  [2][64];
  bit            m_busy [2];
  int            m_rem  [2];
  logic [DW-1:0] exp_q  [2*RP][$];

  always #5 clk = ~clk;

  multiport_register_file #(.DATA_WIDTH(DW), .DEPTH(64), .READ_PORTS(RP)) u_dut64 (
    .clk(clk), .rst(rst), .clear_in(clear_in), .busy_out(busy_w[0]),
    .w_en_in(w_en), .w_addr_in(w_addr), .w_be_in(w_be), .w_data_in(w_data),
    .r_en_in(r_en), .r_addr_in(r_addr), .r_data_out(rdata_w[0]), .r_valid_out(rvalid_w[0])
  );

  multiport_register_file #(.DATA_WIDTH(DW), .DEPTH(48), .READ_PORTS(RP)) u_dut48 (
    .clk(clk), .rst(rst), .clear_in(clear_in), .busy_out(busy_w[1]),
    .w_en_in(w_en), .w_addr_in(w_addr), .w_be_in(w_be), .w_data_in(w_data),
    .r_en_in(r_en), .r_addr_in(r_addr), .r_data_out(rdata_w[1]), .r_valid_out(rvalid_w[1])
  );

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] merge(input logic [DW-1:0] old, input logic [DW-1:0] d,
                                          input logic [3:0] be);
    logic [DW-1:0] r;
    r = old;
    for (int k = 0; k < 4; k++) if (be[k]) r[8*k +: 8] = d[8*k +: 8];
    return r;
  endfunction

  // Reference model: applies the effect of the coming clock edge to the current inputs.
  task automatic model_step();
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        m_busy[i] = 1'b1;
        m_rem[i]  = DEP[i];
        for (int j = 0; j < 64; j++) m_mem[i][j] = '0;
      end else if (m_busy[i]) begin
        m_rem[i]--;
        if (m_rem[i] == 0) m_busy[i] = 1'b0;
      end else begin
        int wa;
        wa = int'(w_addr);
        for (int p = 0; p < RP; p++) begin
          if (r_en[p]) begin
            int ra;
            logic [DW-1:0] e;
            ra = int'(r_addr[p*AW +: AW]);
            e  = '0;
            if (ra < DEP[i]) begin
              e = m_mem[i][ra];
              if (w_en && ra == wa) e = merge(e, w_data, w_be);
            end
            exp_q[i*RP+p].push_back(e);
          end
        end
        if (w_en && wa < DEP[i]) m_mem[i][wa] = merge(m_mem[i][wa], w_data, w_be);
        if (clear_in) begin
          m_busy[i] = 1'b1;
          m_rem[i]  = DEP[i];
          for (int j = 0; j < 64; j++) m_mem[i][j] = '0;
        end
      end
    end
  endtask

  task automatic set_idle();
    clear_in = 1'b0; w_en = 1'b0; w_addr = '0; w_be = '0; w_data = '0;
    r_en = '0; r_addr = '0;
  endtask

  task automatic do_cycle();
    model_step();
    mon_en = 1'b1;
    @(negedge clk);
  endtask

  task automatic do_write(input int a, input logic [DW-1:0] d, input logic [3:0] be);
    w_en = 1'b1; w_addr = AW'(a); w_data = d; w_be = be;
    do_cycle();
    set_idle();
  endtask

  task automatic wait_model_ready();
    int n;
    n = 0;
    while ((m_busy[0] || m_busy[1]) && n < 300) begin
      n++;
      do_cycle();
    end
  endtask

  task automatic count_busy(input string name);
    int n;
    n = 0;
    while (busy_w[0] && n < 200) begin
      n++;
      do_cycle();
    end
    check(name, DW'(n), DW'(64));
  endtask

  // Monitor: pops the scoreboard whenever a port presents valid, checks holds otherwise.
  initial begin
    logic [DW-1:0] last [2][RP];
    logic [DW-1:0] act, e;
    logic          v, exp_v;
    int            qi;
    for (int i = 0; i < 2; i++) for (int p = 0; p < RP; p++) last[i][p] = '0;
    forever begin
      @(posedge clk);
      #1;
      if (mon_en) begin
        for (int i = 0; i < 2; i++) begin
          check($sformatf("dut%0d busy", i), DW'(busy_w[i]), DW'(m_busy[i]));
          for (int p = 0; p < RP; p++) begin
            act = rdata_w[i][p*DW +: DW];
            v   = rvalid_w[i][p];
            qi  = i*RP + p;
            if (rst) begin
              check($sformatf("dut%0d p%0d rst data", i, p), act, '0);
              check($sformatf("dut%0d p%0d rst valid", i, p), DW'(v), '0);
              last[i][p] = '0;
            end else begin
              exp_v = (exp_q[qi].size() > 0);
              check($sformatf("dut%0d p%0d valid", i, p), DW'(v), DW'(exp_v));
              if (exp_v) begin
                e = exp_q[qi].pop_front();
                if (v) check($sformatf("dut%0d p%0d data", i, p), act, e);
                last[i][p] = e;
              end else begin
                check($sformatf("dut%0d p%0d hold", i, p), act, last[i][p]);
              end
            end
          end
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL timeout: simulation did not finish, got running expected done");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 2; i++) begin
      m_busy[i] = 1'b1;
      m_rem[i]  = DEP[i];
    end
    set_idle();
    rst = 1'b1;
    @(negedge clk);

    // Reset sweep: one-cycle pulse, busy for exactly DEPTH cycles.
    do_cycle();
    rst = 1'b0;
    count_busy("reset sweep length");
    wait_model_ready();
    r_en = 2'b01; r_addr[0 +: AW] = AW'(63);
    do_cycle();
    set_idle();
    check("addr63 after sweep data", rdata_w[0][31:0], 32'h0);
    check("addr63 after sweep valid", DW'(rvalid_w[0][0]), DW'(1));

    // Byte-enabled write merge.
    do_write(5, 32'hAABBCCDD, 4'b1111);
    do_write(5, 32'h11223344, 4'b0101);
    r_en = 2'b01; r_addr[0 +: AW] = AW'(5);
    do_cycle();
    set_idle();
    check("byte enable merge", rdata_w[0][31:0], 32'hAA22CC44);

    // Full-word bypass to both ports.
    w_en = 1'b1; w_addr = AW'(9); w_data = 32'hDEADBEEF; w_be = 4'b1111;
    r_en = 2'b11; r_addr = {AW'(9), AW'(9)};
    do_cycle();
    set_idle();
    check("bypass full p0", rdata_w[0][31:0], 32'hDEADBEEF);
    check("bypass full p1", rdata_w[0][63:32], 32'hDEADBEEF);

    // Partial bypass over an older word.
    do_write(9, 32'h12345678, 4'b1111);
    w_en = 1'b1; w_addr = AW'(9); w_data = 32'hDEADBEEF; w_be = 4'b0011;
    r_en = 2'b11; r_addr = {AW'(9), AW'(9)};
    do_cycle();
    set_idle();
    check("bypass partial p0", rdata_w[0][31:0], 32'h1234BEEF);
    check("bypass partial p1", rdata_w[0][63:32], 32'h1234BEEF);

    // Independent ports, then hold on the idle port.
    do_write(1, 32'hA1A1A1A1, 4'b1111);
    do_write(2, 32'hB2B2B2B2, 4'b1111);
    r_en = 2'b11; r_addr = {AW'(2), AW'(1)};
    do_cycle();
    set_idle();
    check("indep p0", rdata_w[0][31:0], 32'hA1A1A1A1);
    check("indep p1", rdata_w[0][63:32], 32'hB2B2B2B2);
    r_en = 2'b01; r_addr[0 +: AW] = AW'(1);
    do_cycle();
    set_idle();
    check("idle port hold data", rdata_w[0][63:32], 32'hB2B2B2B2);
    check("idle port valid low", DW'(rvalid_w[0][1]), DW'(0));

    // clear_in together with a write; accesses during busy are dropped.
    clear_in = 1'b1;
    w_en = 1'b1; w_addr = AW'(3); w_data = 32'h5; w_be = 4'b1111;
    do_cycle();
    set_idle();
    begin
      int n;
      n = 0;
      while (busy_w[0] && n < 200) begin
        if (n < 2) begin
          w_en = 1'b1; w_addr = AW'(3); w_data = 32'h7; w_be = 4'b1111;
          r_en = 2'b01; r_addr[0 +: AW] = AW'(3);
        end
        n++;
        do_cycle();
        set_idle();
        if (n <= 2) check("read while busy valid", DW'(rvalid_w[0][0]), DW'(0));
      end
      check("clear sweep length", DW'(n), DW'(64));
    end
    wait_model_ready();
    r_en = 2'b01; r_addr[0 +: AW] = AW'(3);
    do_cycle();
    set_idle();
    check("addr3 after clear", rdata_w[0][31:0], 32'h0);

    // Reset at sweep cycle 20 restarts the full sweep.
    clear_in = 1'b1;
    do_cycle();
    set_idle();
    for (int c = 0; c < 20; c++) do_cycle();
    rst = 1'b1;
    do_cycle();
    rst = 1'b0;
    count_busy("restarted sweep length");
    wait_model_ready();

    // Out-of-range address on the DEPTH=48 instance.
    w_en = 1'b1; w_addr = AW'(50); w_data = 32'h77; w_be = 4'b1111;
    r_en = 2'b01; r_addr[0 +: AW] = AW'(50);
    do_cycle();
    set_idle();
    check("oor bypass data", rdata_w[1][31:0], 32'h0);
    check("oor bypass valid", DW'(rvalid_w[1][0]), DW'(1));
    r_en = 2'b10; r_addr[AW +: AW] = AW'(50);
    do_cycle();
    set_idle();
    check("oor read data", rdata_w[1][63:32], 32'h0);
    check("oor read valid", DW'(rvalid_w[1][1]), DW'(1));
    check("in range on depth64", rdata_w[0][63:32], 32'h77);

    // Randomized traffic with occasional clear and reset.
    for (int c = 0; c < 2500; c++) begin
      int wa, ra;
      rst      = ($urandom_range(0, 599) == 0);
      clear_in = ($urandom_range(0, 249) == 0);
      w_en     = 1'($urandom_range(0, 1));
      wa       = int'($urandom_range(0, 63));
      w_addr   = AW'(wa);
      w_be     = 4'($urandom);
      w_data   = $urandom;
      r_en     = RP'($urandom);
      for (int p = 0; p < RP; p++) begin
        ra = ($urandom_range(0, 2) == 0) ? wa : int'($urandom_range(0, 63));
        r_addr[p*AW +: AW] = AW'(ra);
      end
      do_cycle();
    end
    rst = 1'b0;
    set_idle();
    wait_model_ready();
    do_cycle();
    do_cycle();
    for (int q = 0; q < 2*RP; q++)
      check($sformatf("scoreboard %0d drained", q), DW'(exp_q[q].size()), DW'(0));

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/multiport_register_file.md
# multiport_register_file

Parametrised storage array with one byte-enabled write port and READ_PORTS independent registered read ports, write-first bypass and a hardware clear sequencer. Successor to the single-port register file used in the datapath. It serves as the operand store for multi-operand units that need several reads per cycle. After reset, or on request, it zeroes its contents one entry per cycle before accepting traffic.

## Interface
- DATA_WIDTH, 32, word width in bits; must be a multiple of 8
- DEPTH, 64, number of entries; need not be a power of two
- READ_PORTS, 2, number of read ports; minimum 1
- ADDR_WIDTH, $clog2(DEPTH) (minimum 1), address width; derived, not overridden
- BE_WIDTH, DATA_WIDTH/8, byte-enable width; derived

Ports:
- clk  in  1  clock; all logic on the rising edge
- rst  in  1  reset, synchronous, active-high
- clear_in  in  1  request a full zeroing sweep
- busy_out  out  1  sweep in progress; writes ignored, reads not served
- w_en_in  in  1  write strobe
- w_addr_in  in  ADDR_WIDTH  write address
- w_be_in  in  BE_WIDTH  byte enables; bit k covers data bits [8k+7:8k]
- w_data_in  in  DATA_WIDTH  write data
- r_en_in  in  READ_PORTS  per-port read strobe
- r_addr_in  in  READ_PORTS*ADDR_WIDTH  port p address at [p*ADDR_WIDTH +: ADDR_WIDTH]
- r_data_out  out  READ_PORTS*DATA_WIDTH  port p data at [p*DATA_WIDTH +: DATA_WIDTH]
- r_valid_out  out  READ_PORTS  per-port data-valid, one-cycle pulse per served read

## Operation
- Two states: CLEAR and READY. A sweep pointer counts 0..DEPTH-1.
- CLEAR:
  - Writes zero to mem[ptr] each cycle and increments ptr.
  - After writing entry DEPTH-1, moves to READY and resets ptr to 0.
- READY:
  - clear_in=1 moves to CLEAR with ptr=0.
  - The write and reads presented in that same cycle are still performed normally.
- rst=1 forces CLEAR with ptr=0, all r_data_out=0 and all r_valid_out=0, whatever else is present.
- clear_in is ignored while in CLEAR. Write and read strobes are ignored while busy_out=1.
- busy_out is registered and equals (state==CLEAR).
- Write: when w_en_in=1 and READY, each byte k with w_be_in[k]=1 is updated. Other bytes keep their value. w_be_in=0 is a no-op.
- Read port p, when r_en_in[p]=1 and READY:
  - r_data_out[p] loads mem[addr_p].
  - r_valid_out[p] is 1 on the next cycle.
- Write-first bypass: if w_en_in=1 and addr_p==w_addr_in in the same cycle, port p returns the merged word. Enabled bytes come from w_data_in, the rest from mem.
- Ports are fully independent. Any number of ports may read the same address, with or without bypass.
- Read not served (r_en_in[p]=0 or busy): r_data_out[p] holds its last value and r_valid_out[p]=0. Outputs never drive z.
- Out-of-range address (addr >= DEPTH): writes are ignored; reads return 0 with r_valid_out=1.

## Timing
- Read latency is 1 cycle: strobe at edge N, data and valid after edge N, visible in cycle N+1.
- Each port sustains one read per cycle. The write port sustains one write per cycle.
- A write at edge N is visible to a non-bypassed read issued in cycle N+1.
- Reset timing:
  - busy_out=1 in the cycle after the rst edge and stays 1 while rst is held.
  - After rst deasserts, the sweep takes DEPTH edges.
  - busy_out falls after the edge that clears entry DEPTH-1. First accepted access is DEPTH cycles after deassertion.
- clear_in=1 in READY at edge N:
  - busy_out=1 from cycle N+1 to cycle N+DEPTH.
  - READY again in cycle N+DEPTH+1.
- rst mid-sweep restarts the sweep from ptr=0.
- All outputs are registered. There are no combinational input-to-output paths.

## Test plan
- Reset sweep, DEPTH=64:
  - Pulse rst for 1 cycle.
  - Expect busy_out high for exactly 64 cycles.
  - Then a read of addr 63 on port 0 returns 0x00000000 with r_valid_out[0]=1 one cycle later.
- Byte-enabled write:
  - Write 0xAABBCCDD to addr 5, be=1111.
  - Then write 0x11223344 to addr 5, be=0101.
  - A read of addr 5 returns 0xAA22CC44.
- Bypass and dual read:
  - In the same cycle, write 0xDEADBEEF to addr 9 (be=1111), port 0 reads addr 9 and port 1 reads addr 9.
  - Both ports return 0xDEADBEEF next cycle.
  - Repeat with be=0011 over old 0x12345678: both return 0x1234BEEF.
- Independent ports:
  - Port 0 reads addr 1, port 1 reads addr 2 in the same cycle.
  - Each returns its own entry. The port with r_en_in=0 the next cycle holds its data with valid=0.
- clear_in mid-traffic:
  - Assert clear_in together with a write of 0x5 to addr 3.
  - Writes during busy must be dropped.
  - After 64 busy cycles, addr 3 reads 0x0.
  - A read strobe issued while busy gives r_valid_out=0.
- Reset mid-sweep and out-of-range:
  - Assert rst at sweep cycle 20; busy lasts 64 more cycles after deassertion.
  - With DEPTH=48, a write to addr 50 is ignored and a read of addr 50 returns 0 with valid=1.
